// File: rtl/rmii_rx_pkg.sv
// Shared types and constants for the RMII receive framer.
// Only the CRC constants matter when RMII_RX_FCS_CHECK_EN is defined.
package rmii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } rx_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;
  localparam logic [3:0]  DIV10_MAX      = 4'd9;

  // Bit-reverse a 32-bit word; the Ethernet CRC runs LSB-first.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/rmii_rx_framer_crc.sv
// Combinational single-byte update of the reflected Ethernet CRC32.
// Instanced by rmii_rx_framer only when RMII_RX_FCS_CHECK_EN is defined.
module eth_crc32_d8
  import rmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  // Shift the byte in LSB first, one bit per iteration.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD and packs dibits into an
// 8-bit AXI-stream with no backpressure. Optional FCS check is enabled
// with the RMII_RX_FCS_CHECK_EN macro.
//
// Stream handshake: rx_axis_tvalid is a one-cycle beat strobe with no
// tready; tdata/tlast/tuser are meaningful only while tvalid is high and
// tuser is meaningful only on the tlast beat.
module rmii_rx_framer
  import rmii_rx_pkg::*;
#(
  parameter int RATE_10_100 = 0
)
(
  input  logic       clk_int,
  input  logic       rst_int,
  input  logic [1:0] phy_rxd,
  input  logic       phy_crs_dv,
  input  logic       phy_rx_er,
  output logic [7:0] rx_axis_tdata,
  output logic       rx_axis_tvalid,
  output logic       rx_axis_tlast,
  output logic       rx_axis_tuser,
  output logic       rx_error_bad_frame,
  output logic       rx_error_bad_fcs
);

  rx_state_e  state, state_next;
  logic [3:0] div_cnt;
  logic       sample;
  logic       frame_start, accept, eof;
  logic [1:0] held_rxd;
  logic       held_crs, held_valid;
  logic [1:0] dibit_idx;
  logic [5:0] shift;
  logic [7:0] hold_byte, new_byte;
  logic       hold_valid, bad_er;
  logic       byte_done, er_now, bad_cause, fcs_bad;

  // Free-running 0..9 divider; only consulted at 10 Mb/s.
  always_ff @(posedge clk_int) begin
    if (rst_int)                 div_cnt <= 4'd0;
    else if (div_cnt == DIV10_MAX) div_cnt <= 4'd0;
    else                         div_cnt <= div_cnt + 4'd1;
  end

  assign sample    = (RATE_10_100 == 0) ? 1'b1 : (div_cnt == DIV10_MAX);
  assign new_byte  = {held_rxd, shift};
  assign byte_done = accept && (dibit_idx == 2'd3);
  assign er_now    = sample && (state == DATA) && phy_rx_er;
  assign bad_cause = bad_er || er_now || (dibit_idx != 2'd0);

  // State register.
  always_ff @(posedge clk_int) begin
    if (rst_int) state <= IDLE;
    else         state <= state_next;
  end

  // Next state plus frame control strobes; a held dibit is data unless it
  // and the current sample are both carrier-low (RMII end of carrier).
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    accept      = 1'b0;
    eof         = 1'b0;
    if (sample) begin
      case (state)
        IDLE: begin
          if (phy_crs_dv && (phy_rxd == PREAMBLE_DIBIT)) state_next = PREAMBLE;
        end
        PREAMBLE: begin
          if (!phy_crs_dv)                    state_next = IDLE;
          else if (phy_rxd == PREAMBLE_DIBIT) state_next = PREAMBLE;
          else if (phy_rxd == SFD_DIBIT) begin
            state_next  = DATA;
            frame_start = 1'b1;
          end
          else                                state_next = IDLE;
        end
        DATA: begin
          if (held_valid) begin
            if (!held_crs && !phy_crs_dv) begin
              eof        = 1'b1;
              state_next = IDLE;
            end
            else accept = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc, crc_next;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (new_byte),
    .crc_out (crc_next)
  );

  // Running CRC over every completed byte, FCS included.
  always_ff @(posedge clk_int) begin
    if (rst_int)          crc <= CRC_INIT;
    else if (frame_start) crc <= CRC_INIT;
    else if (byte_done)   crc <= crc_next;
  end

  assign fcs_bad = (crc != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  // Lookahead register, byte assembly, one-byte output hold and stream outputs.
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      held_rxd           <= 2'b00;
      held_crs           <= 1'b0;
      held_valid         <= 1'b0;
      dibit_idx          <= 2'd0;
      shift              <= 6'd0;
      hold_byte          <= 8'd0;
      hold_valid         <= 1'b0;
      bad_er             <= 1'b0;
      rx_axis_tdata      <= 8'd0;
      rx_axis_tvalid     <= 1'b0;
      rx_axis_tlast      <= 1'b0;
      rx_axis_tuser      <= 1'b0;
      rx_error_bad_frame <= 1'b0;
      rx_error_bad_fcs   <= 1'b0;
    end
    else begin
      rx_axis_tvalid     <= 1'b0;
      rx_axis_tlast      <= 1'b0;
      rx_axis_tuser      <= 1'b0;
      rx_error_bad_frame <= 1'b0;
      rx_error_bad_fcs   <= 1'b0;
      if (frame_start) begin
        held_valid <= 1'b0;
        dibit_idx  <= 2'd0;
        hold_valid <= 1'b0;
        bad_er     <= 1'b0;
      end
      if (sample && (state == DATA)) begin
        held_rxd   <= phy_rxd;
        held_crs   <= phy_crs_dv;
        held_valid <= 1'b1;
        if (phy_rx_er) bad_er <= 1'b1;
      end
      if (accept) begin
        shift     <= {held_rxd, shift[5:2]};
        dibit_idx <= dibit_idx + 2'd1;
        if (byte_done) begin
          hold_byte  <= new_byte;
          hold_valid <= 1'b1;
          if (hold_valid) begin
            rx_axis_tdata  <= hold_byte;
            rx_axis_tvalid <= 1'b1;
          end
        end
      end
      if (eof) begin
        if (hold_valid) begin
          rx_axis_tdata      <= hold_byte;
          rx_axis_tvalid     <= 1'b1;
          rx_axis_tlast      <= 1'b1;
          rx_axis_tuser      <= bad_cause || fcs_bad;
          rx_error_bad_frame <= bad_cause;
          rx_error_bad_fcs   <= fcs_bad;
        end
        hold_valid <= 1'b0;
        held_valid <= 1'b0;
        dibit_idx  <= 2'd0;
        bad_er     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Bench for rmii_rx_framer: a 100 Mb/s instance driven from a vector table
// plus hand sequences for reset mid-frame and a 10 Mb/s instance.
module tb_rmii_rx_framer;

  logic clk_int = 1'b0;
  always #10 clk_int = ~clk_int;

  logic       rst_int = 1'b1;
  logic [1:0] phy_rxd = 2'b00;
  logic       phy_crs_dv = 1'b0, phy_rx_er = 1'b0;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser;
  logic       rx_error_bad_frame, rx_error_bad_fcs;

  logic [1:0] s_rxd = 2'b00;
  logic       s_crs = 1'b0, s_er = 1'b0;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser, s_bad_frame, s_bad_fcs;

`ifdef RMII_RX_FCS_CHECK_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  rmii_rx_framer #(.RATE_10_100(0)) dut (
    .clk_int(clk_int), .rst_int(rst_int),
    .phy_rxd(phy_rxd), .phy_crs_dv(phy_crs_dv), .phy_rx_er(phy_rx_er),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
    .rx_error_bad_frame(rx_error_bad_frame), .rx_error_bad_fcs(rx_error_bad_fcs)
  );

  rmii_rx_framer #(.RATE_10_100(1)) dut_slow (
    .clk_int(clk_int), .rst_int(rst_int),
    .phy_rxd(s_rxd), .phy_crs_dv(s_crs), .phy_rx_er(s_er),
    .rx_axis_tdata(s_tdata), .rx_axis_tvalid(s_tvalid),
    .rx_axis_tlast(s_tlast), .rx_axis_tuser(s_tuser),
    .rx_error_bad_frame(s_bad_frame), .rx_error_bad_fcs(s_bad_fcs)
  );

  typedef struct {
    int kind;       // 0 = full frame, 1 = preamble+SFD then end
    int flip_byte;  // byte whose bit0 is flipped after FCS, -1 none
    int er_byte;    // byte with rx_er on its first dibit, -1 none
    int tail;       // 0 plain, 1 crs toggle 0,1,0,1 on last byte, 2 three extra dibits
    int exp_beats;
    bit exp_user;
    bit exp_bad_frame;
    bit exp_bad_fcs;
  } vec_t;

  vec_t vecs[6];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [9:0] got_q[$];     // {tuser, tlast, tdata}
  logic [9:0] s_got_q[$];
  int fr_pulses = 0, fcs_pulses = 0, pulse_misalign = 0;
  int fast_gap = 100, gap_viol = 0;
  int s_consec = 0;
  logic s_prev_valid = 1'b0;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk_int) begin
    if (rx_axis_tvalid) begin
      got_q.push_back({rx_axis_tuser, rx_axis_tlast, rx_axis_tdata});
      if (!rx_axis_tlast && fast_gap < 3) gap_viol++;
      fast_gap = 0;
    end
    else if (fast_gap < 100) fast_gap++;
    if (rx_error_bad_frame) begin
      fr_pulses++;
      if (!rx_axis_tlast) pulse_misalign++;
    end
    if (rx_error_bad_fcs) begin
      fcs_pulses++;
      if (!rx_axis_tlast) pulse_misalign++;
    end
    if (s_tvalid) begin
      s_got_q.push_back({s_tuser, s_tlast, s_tdata});
      if (s_prev_valid) s_consec++;
    end
    s_prev_valid = s_tvalid;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] eth_fcs(input logic [7:0] b[$]);
    logic [31:0] c;
    logic [7:0]  x;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      x = b[i];
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ x[k]) c = (c >> 1) ^ 32'hEDB88320;
        else             c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic logic [9:0] get_item(input bit slow, input int idx);
    if (slow) return s_got_q[idx];
    return got_q[idx];
  endfunction

  function automatic int q_size(input bit slow);
    if (slow) return s_got_q.size();
    return got_q.size();
  endfunction

  task automatic drive(input bit slow, input logic [1:0] d, input logic crs, input logic er);
    if (slow) begin
      s_rxd = d; s_crs = crs; s_er = er;
      repeat (10) @(posedge clk_int);
      #1;
    end
    else begin
      phy_rxd = d; phy_crs_dv = crs; phy_rx_er = er;
      @(posedge clk_int);
      #1;
    end
  endtask

  // Builds a 60-byte payload + FCS into exp_q and drives the frame.
  // stop_after >= 0 ends driving after that byte (no end-of-carrier).
  task automatic send_frame(input bit slow, input vec_t v, input int stop_after);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    logic [7:0]  b;
    logic        crs;
    for (int i = 0; i < 60; i++) fr.push_back(8'((i * 7 + 3) & 255));
    fcs = eth_fcs(fr);
    for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
    if (v.flip_byte >= 0) fr[v.flip_byte] = fr[v.flip_byte] ^ 8'h01;
    exp_q.delete();
    if (v.kind == 0) foreach (fr[i]) exp_q.push_back(fr[i]);
    for (int i = 0; i < 31; i++) drive(slow, 2'b01, 1'b1, 1'b0);
    drive(slow, 2'b11, 1'b1, 1'b0);
    if (v.kind == 0) begin
      for (int n = 0; n < 64; n++) begin
        if (stop_after >= 0 && n > stop_after) break;
        b = fr[n];
        for (int j = 0; j < 4; j++) begin
          crs = 1'b1;
          if (v.tail == 1 && n == 63) crs = (j % 2 == 1);
          drive(slow, b[2*j +: 2], crs, (n == v.er_byte && j == 0));
        end
      end
      if (v.tail == 2) repeat (3) drive(slow, 2'b10, 1'b1, 1'b0);
    end
    if (stop_after < 0) repeat (8) drive(slow, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input bit slow, input vec_t v,
                             input int base, input int fr0, input int fcs0, input int mis0);
    int n, mism, lastcnt;
    logic [9:0] it;
    n = q_size(slow) - base;
    mism = 0;
    lastcnt = 0;
    check({tag, "_beats"}, n, v.exp_beats);
    for (int i = 0; i < n; i++) begin
      it = get_item(slow, base + i);
      if (i >= exp_q.size() || it[7:0] !== exp_q[i]) mism++;
      if (it[8]) lastcnt++;
    end
    check({tag, "_data_mismatches"}, mism, 0);
    check({tag, "_tlast_count"}, lastcnt, (v.exp_beats > 0) ? 1 : 0);
    if (n > 0) begin
      it = get_item(slow, base + n - 1);
      check({tag, "_tlast_on_final"}, it[8], 1'b1);
      check({tag, "_tuser"}, it[9], v.exp_user);
    end
    if (!slow) begin
      check({tag, "_bad_frame_pulses"}, fr_pulses - fr0, v.exp_bad_frame);
      check({tag, "_bad_fcs_pulses"}, fcs_pulses - fcs0, v.exp_bad_fcs);
      check({tag, "_pulse_without_tlast"}, pulse_misalign - mis0, 0);
    end
  endtask

  initial begin
    int base, fr0, fcs0, mis0;
    vecs[0] = '{0, -1, -1, 0, 64, 1'b0, 1'b0, 1'b0};     // clean frame
    vecs[1] = '{0, 10, -1, 0, 64, FCS_ON, 1'b0, FCS_ON}; // corrupted payload
    vecs[2] = '{0, -1, 20, 0, 64, 1'b1, 1'b1, 1'b0};     // rx_er at byte 20
    vecs[3] = '{0, -1, -1, 1, 64, 1'b0, 1'b0, 1'b0};     // crs_dv toggle at end
    vecs[4] = '{0, -1, -1, 2, 64, 1'b1, 1'b1, 1'b0};     // trailing partial byte
    vecs[5] = '{1, -1, -1, 0, 0, 1'b0, 1'b0, 1'b0};      // SFD, no data

    // Reset block.
    rst_int = 1'b1;
    repeat (3) @(posedge clk_int);
    #1;
    check("reset_fast_outputs",
          {rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, rx_error_bad_frame, rx_error_bad_fcs}, 0);
    check("reset_slow_outputs", {s_tdata, s_tvalid, s_tlast, s_tuser, s_bad_frame, s_bad_fcs}, 0);
    rst_int = 1'b0;
    repeat (4) drive(1'b0, 2'b00, 1'b0, 1'b0);

    // Table-driven frames at 100 Mb/s.
    for (int t = 0; t < 6; t++) begin
      base = got_q.size(); fr0 = fr_pulses; fcs0 = fcs_pulses; mis0 = pulse_misalign;
      send_frame(1'b0, vecs[t], -1);
      check_frame($sformatf("vec%0d", t), 1'b0, vecs[t], base, fr0, fcs0, mis0);
    end

    // Reset one clock after byte 20 has been driven, then a clean frame.
    base = got_q.size();
    send_frame(1'b0, vecs[0], 20);
    phy_crs_dv = 1'b0;
    phy_rxd = 2'b00;
    rst_int = 1'b1;
    @(posedge clk_int);
    #1;
    check("midreset_outputs_low", {rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, rx_error_bad_frame}, 0);
    rst_int = 1'b0;
    repeat (8) drive(1'b0, 2'b00, 1'b0, 1'b0);
    begin
      int lastcnt;
      lastcnt = 0;
      for (int i = base; i < got_q.size(); i++) if (got_q[i][8]) lastcnt++;
      check("midreset_no_tlast", lastcnt, 0);
      check("midreset_beats_before_reset", got_q.size() - base, 19);
    end
    base = got_q.size(); fr0 = fr_pulses; fcs0 = fcs_pulses; mis0 = pulse_misalign;
    send_frame(1'b0, vecs[0], -1);
    check_frame("after_reset", 1'b0, vecs[0], base, fr0, fcs0, mis0);

    check("beat_spacing_violations", gap_viol, 0);

    // 10 Mb/s instance, each dibit held for 10 clocks.
    base = s_got_q.size();
    send_frame(1'b1, vecs[0], -1);
    check_frame("slow", 1'b1, vecs[0], base, 0, 0, 0);
    check("slow_back_to_back_tvalid", s_consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
